// File: rtl/overlay_mixer_pkg.sv
// Shared types and constants for the overlay mixer: FSM state encoding,
// colour constants, the stage-1 pixel bundle and the colour priority rule.
package overlay_mixer_pkg;

  localparam int V_ACTIVE_DEF = 480;
  localparam int LINE_W       = 10;
  localparam int HOLD_W       = 8;
  localparam int RGB_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REVEAL  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_CONCEAL = 2'd3
  } state_e;

  localparam logic [RGB_W-1:0] RGB_BLACK = 6'b000000;
  localparam logic [RGB_W-1:0] RGB_WHITE = 6'b111111;

  typedef struct packed {
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             text_draw;
    logic             em_vis;
    logic [RGB_W-1:0] text_rgb;
    logic [RGB_W-1:0] emblem_rgb;
    logic [RGB_W-1:0] pattern_rgb;
  } pix_s;

  // Blanking beats everything, then text, then the gated emblem, then background.
  function automatic logic [RGB_W-1:0] mix_colour(input pix_s p);
    if (!p.active)       return RGB_BLACK;
    else if (p.text_draw) return p.text_rgb;
    else if (p.em_vis)    return p.emblem_rgb;
    else                  return p.pattern_rgb;
  endfunction

endpackage

// File: rtl/reveal_ctrl.sv
// Per-frame emblem animation: vsync rise detector, IDLE/REVEAL/HOLD/CONCEAL
// FSM, reveal line and hold counter. Everything moves only on frame events.
module reveal_ctrl
  import overlay_mixer_pkg::*;
#(
  parameter int REVEAL_STEP = 4,
  parameter int HOLD_FRAMES = 120,
  parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_i,
  input  logic              enable_i,
  output logic [LINE_W-1:0] reveal_line_o,
  output logic              busy_o
);

  localparam logic [LINE_W:0] STEP_X = (LINE_W+1)'(REVEAL_STEP);
  localparam logic [LINE_W:0] VACT_X = (LINE_W+1)'(V_ACTIVE);
  localparam logic [HOLD_W:0] HOLD_X = (HOLD_W+1)'(HOLD_FRAMES);

  state_e              state_q;
  logic [LINE_W-1:0]   reveal_line_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                busy_q;
  logic                vsync_q;
  logic                sample_vld_q;

  logic                frame_evt;
  logic [LINE_W:0]     line_ext, line_sum, line_up, line_dn;
  logic [HOLD_W:0]     hold_inc;
  logic                hold_done;

  // sample_vld_q keeps the first clock after reset from treating a vsync
  // that was already high as a fresh rise.
  assign frame_evt = vsync_i & ~vsync_q & sample_vld_q;

  always_comb begin
    line_ext  = {1'b0, reveal_line_q};
    line_sum  = line_ext + STEP_X;
    line_up   = (line_sum >= VACT_X) ? VACT_X : line_sum;
    line_dn   = (line_ext <= STEP_X) ? '0 : line_ext - STEP_X;
    hold_inc  = {1'b0, hold_cnt_q} + 1'b1;
    hold_done = (hold_inc >= HOLD_X);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      reveal_line_q <= '0;
      hold_cnt_q    <= '0;
      busy_q        <= 1'b0;
      vsync_q       <= 1'b0;
      sample_vld_q  <= 1'b0;
    end else begin
      vsync_q      <= vsync_i;
      sample_vld_q <= 1'b1;
      if (frame_evt) begin
        if (!enable_i) begin
          state_q       <= ST_IDLE;
          reveal_line_q <= '0;
          hold_cnt_q    <= '0;
          busy_q        <= 1'b0;
        end else begin
          busy_q <= 1'b1;
          unique case (state_q)
            // IDLE always holds reveal_line at 0, so it shares REVEAL's step.
            ST_IDLE, ST_REVEAL: begin
              reveal_line_q <= line_up[LINE_W-1:0];
              if (line_up == VACT_X) begin
                state_q    <= ST_HOLD;
                hold_cnt_q <= '0;
              end else begin
                state_q <= ST_REVEAL;
              end
            end
            ST_HOLD: begin
              if (hold_done) begin
                state_q    <= ST_CONCEAL;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_inc[HOLD_W-1:0];
              end
            end
            ST_CONCEAL: begin
              reveal_line_q <= line_dn[LINE_W-1:0];
              if (line_dn == '0) state_q <= ST_REVEAL;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign reveal_line_o = reveal_line_q;
  assign busy_o        = busy_q;

endmodule

// File: rtl/overlay_mixer.sv
// Two-stage pixel compositor: stage 1 registers the pixel inputs plus the
// reveal-gated emblem flag, stage 2 registers the prioritised colour.
module overlay_mixer
  import overlay_mixer_pkg::*;
#(
  parameter int REVEAL_STEP = 4,
  parameter int HOLD_FRAMES = 120,
  parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LINE_W-1:0] y,
  input  logic             active,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] pattern_rgb,
  input  logic             emblem_draw,
  input  logic [RGB_W-1:0] emblem_rgb,
  input  logic             text_draw,
  input  logic [RGB_W-1:0] text_rgb,
  input  logic             enable,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             busy
);

  logic [LINE_W-1:0] reveal_line;
  pix_s              s1_d, s1_q;
  logic [RGB_W-1:0]  rgb_q;
  logic              hsync_q, vsync_q;

  reveal_ctrl #(
    .REVEAL_STEP(REVEAL_STEP),
    .HOLD_FRAMES(HOLD_FRAMES),
    .V_ACTIVE   (V_ACTIVE)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (vsync_in),
    .enable_i     (enable),
    .reveal_line_o(reveal_line),
    .busy_o       (busy)
  );

  // reveal_line is read live here; it only moves at the vsync rise, which
  // falls after the last visible row, so a frame never sees two values.
  always_comb begin
    s1_d.active      = active;
    s1_d.hsync       = hsync_in;
    s1_d.vsync       = vsync_in;
    s1_d.text_draw   = text_draw;
    s1_d.em_vis      = emblem_draw & (y < reveal_line);
    s1_d.text_rgb    = text_rgb;
    s1_d.emblem_rgb  = emblem_rgb;
    s1_d.pattern_rgb = pattern_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      rgb_q   <= RGB_BLACK;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      rgb_q   <= mix_colour(s1_q);
      hsync_q <= s1_q.hsync;
      vsync_q <= s1_q.vsync;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_overlay_mixer.sv
// Self-checking bench for overlay_mixer: directed steps plus a randomized
// pixel stream scored against a frame-level model of the reveal animation.
module tb_overlay_mixer;
  import overlay_mixer_pkg::*;

  localparam int STEP = 4;
  localparam int HF   = 2;
  localparam int VA   = 480;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] y;
  logic       active, hsync_in, vsync_in;
  logic [5:0] pattern_rgb, emblem_rgb, text_rgb;
  logic       emblem_draw, text_draw, enable;
  logic [5:0] rgb_out;
  logic       hsync_out, vsync_out, busy;

  int checks = 0;
  int errors = 0;

  // Frame-level animation model
  state_e m_state = ST_IDLE;
  int     m_line  = 0;
  int     m_hold  = 0;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
  } exp_s;
  exp_s exp_q[$];

  overlay_mixer #(
    .REVEAL_STEP(STEP),
    .HOLD_FRAMES(HF),
    .V_ACTIVE   (VA)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .active     (active),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pattern_rgb(pattern_rgb),
    .emblem_draw(emblem_draw),
    .emblem_rgb (emblem_rgb),
    .text_draw  (text_draw),
    .text_rgb   (text_rgb),
    .enable     (enable),
    .rgb_out    (rgb_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ref_rgb(input logic act, input logic td, input logic ed,
                                         input int yy, input int line,
                                         input logic [5:0] tr, input logic [5:0] er,
                                         input logic [5:0] pr);
    if (!act)                    return 6'h00;
    if (td)                      return tr;
    if (ed && (yy < line))       return er;
    return pr;
  endfunction

  task automatic model_frame();
    if (!enable) begin
      m_state = ST_IDLE;
      m_line  = 0;
      m_hold  = 0;
    end else begin
      case (m_state)
        ST_IDLE, ST_REVEAL: begin
          m_line = (m_line + STEP > VA) ? VA : m_line + STEP;
          if (m_line == VA) begin
            m_state = ST_HOLD;
            m_hold  = 0;
          end else m_state = ST_REVEAL;
        end
        ST_HOLD: begin
          m_hold++;
          if (m_hold == HF) m_state = ST_CONCEAL;
        end
        default: begin
          m_line = (m_line < STEP) ? 0 : m_line - STEP;
          if (m_line == 0) m_state = ST_REVEAL;
        end
      endcase
    end
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    tick();
    model_frame();
    tick();
    vsync_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic probe(input string tag, input int yy, input logic act, input logic td,
                       input logic ed, input logic [5:0] tr, input logic [5:0] er,
                       input logic [5:0] pr);
    y = 10'(yy); active = act; text_draw = td; emblem_draw = ed;
    text_rgb = tr; emblem_rgb = er; pattern_rgb = pr;
    tick();
    tick();
    check(tag, 32'(rgb_out), 32'(ref_rgb(act, td, ed, yy, m_line, tr, er, pr)));
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_line"},  32'(u_dut.reveal_line),   32'(m_line));
    check({tag, "_state"}, 32'(u_dut.u_ctrl.state_q), 32'(m_state));
    check({tag, "_busy"},  32'(busy),                32'(m_state != ST_IDLE));
  endtask

  initial begin
    rst_n = 1'b0; y = '0; active = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    pattern_rgb = '0; emblem_rgb = '0; text_rgb = '0;
    emblem_draw = 1'b0; text_draw = 1'b0; enable = 1'b0;

    #12;
    check("rst_rgb",   32'(rgb_out),   32'h0);
    check("rst_hsync", 32'(hsync_out), 32'h0);
    check("rst_vsync", 32'(vsync_out), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    rst_n = 1'b1;
    tick();

    // Single-clock hsync pulse must reappear exactly two clocks later
    hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    check("lat_hs_t1", 32'(hsync_out), 32'h0);
    tick();
    check("lat_hs_t2", 32'(hsync_out), 32'h1);
    tick();
    check("lat_hs_t3", 32'(hsync_out), 32'h0);

    // Three frame events reveal twelve rows
    enable = 1'b1;
    repeat (3) frame();
    check("reveal_12_line", 32'(u_dut.reveal_line), 32'd12);
    check_ctrl("reveal3");
    probe("reveal_y11", 11, 1'b1, 1'b0, 1'b1, 6'h3F, 6'h30, 6'h0C);
    probe("reveal_y12", 12, 1'b1, 1'b0, 1'b1, 6'h3F, 6'h30, 6'h0C);

    probe("prio_text",   5, 1'b1, 1'b1, 1'b1, 6'h3F, 6'h30, 6'h0C);
    probe("prio_emblem", 5, 1'b1, 1'b0, 1'b1, 6'h3F, 6'h30, 6'h0C);
    probe("prio_pattern",5, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h30, 6'h0C);
    probe("prio_blank",  5, 1'b0, 1'b1, 1'b1, 6'h3F, 6'h30, 6'h0C);

    // Randomized pixel stream, scored two clocks behind
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      exp_s e;
      y           = 10'($urandom_range(0, 31));
      active      = 1'($urandom);
      hsync_in    = 1'($urandom);
      text_draw   = ($urandom_range(0, 3) == 0);
      emblem_draw = 1'($urandom);
      text_rgb    = 6'($urandom);
      emblem_rgb  = 6'($urandom);
      pattern_rgb = 6'($urandom);
      e.rgb = ref_rgb(active, text_draw, emblem_draw, int'(y), m_line,
                      text_rgb, emblem_rgb, pattern_rgb);
      e.hs  = hsync_in;
      exp_q.push_back(e);
      tick();
      if (exp_q.size() == 2) begin
        exp_s o;
        o = exp_q.pop_front();
        check("rand_rgb", 32'(rgb_out),   32'(o.rgb));
        check("rand_hs",  32'(hsync_out), 32'(o.hs));
      end
    end
    hsync_in = 1'b0;

    // Run up to saturation: HOLD after frame 120, CONCEAL two frames later
    for (int f = 4; f <= 120; f++) begin
      frame();
      check("sat_busy", 32'(busy), 32'h1);
      check("sat_line", 32'(u_dut.reveal_line), 32'(m_line));
    end
    check("sat_hold_state", 32'(u_dut.u_ctrl.state_q), 32'(ST_HOLD));
    check("sat_line_max",   32'(u_dut.reveal_line),   32'(VA));
    frame();
    check("hold1_state", 32'(u_dut.u_ctrl.state_q), 32'(ST_HOLD));
    check("hold1_busy",  32'(busy), 32'h1);
    frame();
    check("conceal_state", 32'(u_dut.u_ctrl.state_q), 32'(ST_CONCEAL));
    check("conceal_busy",  32'(busy), 32'h1);

    while (m_line > 200) begin
      frame();
      check_ctrl("conceal");
    end
    check("conceal_at_200", 32'(u_dut.reveal_line), 32'd200);

    // Drop enable mid-frame: nothing moves until the next vsync rise
    enable = 1'b0;
    repeat (10) tick();
    check("dis_hold_line", 32'(u_dut.reveal_line), 32'd200);
    check("dis_hold_busy", 32'(busy), 32'h1);
    probe("dis_y199", 199, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h01);
    frame();
    check("dis_line", 32'(u_dut.reveal_line),   32'd0);
    check("dis_state",32'(u_dut.u_ctrl.state_q), 32'(ST_IDLE));
    check("dis_busy", 32'(busy), 32'h0);
    probe("dis_y0", 0, 1'b1, 1'b0, 1'b1, 6'h15, 6'h2A, 6'h01);

    // Asynchronous reset mid-animation with vsync held high
    enable = 1'b1;
    repeat (3) frame();
    check_ctrl("pre_rst");
    probe("pre_rst_text", 3, 1'b1, 1'b1, 1'b0, 6'h3F, 6'h00, 6'h00);
    vsync_in = 1'b1;
    tick();
    model_frame();
    tick();
    check("pre_rst_vs", 32'(vsync_out), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = ST_IDLE; m_line = 0; m_hold = 0;
    check("arst_rgb",   32'(rgb_out),   32'h0);
    check("arst_hsync", 32'(hsync_out), 32'h0);
    check("arst_vsync", 32'(vsync_out), 32'h0);
    check("arst_busy",  32'(busy),      32'h0);
    #3;
    rst_n = 1'b1;
    repeat (5) tick();
    check_ctrl("post_rst_vs_high");
    vsync_in = 1'b0;
    tick();
    tick();
    check_ctrl("post_rst_vs_low");
    frame();
    check_ctrl("restart");
    check("restart_line", 32'(u_dut.reveal_line), 32'(STEP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
